// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle logic/arith ops and multi-cycle SHL/MUL.
// Ports: clk, rst_n (async low); Ain/Bin/ALUop/in_valid/in_ready (request side);
//        out/Z/N/V/out_valid/out_ready (result side, all registered).
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    input  logic [2:0]       ALUop,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             Z,
    output logic             N,
    output logic             V,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOTB = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [2:0]         r_op;
    // MUL: {partial product, remaining multiplier bits}; SHL: low half shifts.
    logic [2*WIDTH-1:0] r_p;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_out;
    logic               r_z;
    logic               r_n;
    logic               r_v;
    logic               r_in_ready;
    logic               r_out_valid;

    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_dif;
    logic [WIDTH-1:0]   w_res;
    logic               w_v;
    logic [WIDTH:0]     w_add;
    logic [2*WIDTH-1:0] w_p_next;
    logic               w_mul;
    logic               w_shl_go;
    logic               w_busy_mul;

    assign w_sum = Ain + Bin;
    assign w_dif = Ain - Bin;

    always_comb begin
        w_res = '0;
        w_v   = 1'b0;
        case (ALUop)
            OP_ADD: begin
                w_res = w_sum;
                w_v   = (Ain[WIDTH-1] == Bin[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != Ain[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_dif;
                w_v   = (Ain[WIDTH-1] != Bin[WIDTH-1]) &&
                        (w_dif[WIDTH-1] != Ain[WIDTH-1]);
            end
            OP_AND:  w_res = Ain & Bin;
            OP_NOTB: w_res = ~Bin;
            OP_OR:   w_res = Ain | Bin;
            OP_XOR:  w_res = Ain ^ Bin;
            OP_SHL:  w_res = Ain;
            default: w_res = '0;
        endcase
    end

    assign w_mul      = (ALUop == OP_MUL);
    assign w_shl_go   = (ALUop == OP_SHL) && (Bin[SW-1:0] != '0);
    assign w_busy_mul = (r_op == OP_MUL);

    // One shift-add step: add multiplicand if current multiplier bit set, shift right.
    assign w_add = {1'b0, r_p[2*WIDTH-1:WIDTH]} +
                   {1'b0, (r_p[0] ? r_a : '0)};

    assign w_p_next = w_busy_mul ?
                      {w_add, r_p[WIDTH-1:1]} :
                      {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-2:0], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_op        <= '0;
            r_p         <= '0;
            r_cnt       <= '0;
            r_out       <= '0;
            r_z         <= 1'b0;
            r_n         <= 1'b0;
            r_v         <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a  <= Ain;
                        r_op <= ALUop;
                        if (w_mul) begin
                            r_p        <= {{WIDTH{1'b0}}, Bin};
                            r_cnt      <= CW'(WIDTH);
                            r_state    <= S_BUSY;
                            r_in_ready <= 1'b0;
                        end else if (w_shl_go) begin
                            r_p        <= {{WIDTH{1'b0}}, Ain};
                            r_cnt      <= {1'b0, Bin[SW-1:0]};
                            r_state    <= S_BUSY;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_out       <= w_res;
                            r_z         <= (w_res == '0);
                            r_n         <= w_res[WIDTH-1];
                            r_v         <= w_v;
                            r_cnt       <= '0;
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    r_p   <= w_p_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_out       <= w_p_next[WIDTH-1:0];
                        r_z         <= (w_p_next[WIDTH-1:0] == '0);
                        r_n         <= w_p_next[WIDTH-1];
                        r_v         <= w_busy_mul &&
                                       (w_p_next[2*WIDTH-1:WIDTH] != '0);
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out       = r_out;
    assign Z         = r_z;
    assign N         = r_n;
    assign V         = r_v;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: random + directed checks of alu_seq against an arithmetic model.
// Latency is counted in clock edges from the accept edge to out_valid rising.
module tb_alu_seq;

    localparam int W = 16;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  Ain;
    logic [W-1:0]  Bin;
    logic [2:0]    ALUop;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  out;
    logic          Z;
    logic          N;
    logic          V;
    logic          out_valid;
    logic          out_ready;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Ain       (Ain),
        .Bin       (Bin),
        .ALUop     (ALUop),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .Z         (Z),
        .N         (N),
        .V         (V),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [2:0] op,
                                  output logic [W-1:0] r, output logic v,
                                  output int lat);
        int          sa;
        int          sb;
        int          s;
        longint unsigned p;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        v   = 1'b0;
        lat = 0;
        case (op)
            3'd0: begin
                s = sa + sb;
                r = W'(s);
                v = (s > 32767) || (s < -32768);
            end
            3'd1: begin
                s = sa - sb;
                r = W'(s);
                v = (s > 32767) || (s < -32768);
            end
            3'd2: r = a & b;
            3'd3: r = ~b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: begin
                s   = int'(b % 16);
                p   = longint'(a) * (64'd1 << s);
                r   = W'(p);
                lat = s;
            end
            default: begin
                p   = longint'(a) * longint'(b);
                r   = W'(p);
                v   = (p >= 64'd65536);
                lat = W;
            end
        endcase
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] op, input int hold);
        logic [W-1:0] er;
        logic         ev;
        int           el;
        int           n;
        logic         bad;
        logic         bad2;
        model(a, b, op, er, ev, el);
        chk("in_ready_idle", in_ready, 1);
        Ain      = a;
        Bin      = b;
        ALUop    = op;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        Ain      = W'($urandom);
        Bin      = W'($urandom);
        ALUop    = 3'($urandom);
        n   = 0;
        bad = 1'b0;
        while (!out_valid && n < 64) begin
            if (in_ready) bad = 1'b1;
            in_valid = 1'($urandom);
            Ain      = W'($urandom);
            Bin      = W'($urandom);
            ALUop    = 3'($urandom);
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, el);
        chk("busy_in_ready", bad, 0);
        chk("out", out, er);
        chk("Z", Z, (er == '0));
        chk("N", N, er[W-1]);
        chk("V", V, ev);
        bad2 = 1'b0;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            Ain      = W'($urandom);
            @(posedge clk); #1;
            if (out !== er || !out_valid || in_ready) bad2 = 1'b1;
        end
        chk("hold_stable", bad2, 0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        ALUop     = 3'd0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("out_valid_drop", out_valid, 0);
        chk("in_ready_back", in_ready, 1);
        chk("out_retain", out, er);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic bad;
        rst_n     = 1'b0;
        Ain       = '0;
        Bin       = '0;
        ALUop     = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", out, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_flags", {Z, N, V}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);

        run_op(16'h0006, 16'h0004, 3'd0, 0);
        run_op(16'h0008, 16'h0008, 3'd1, 0);
        run_op(16'h1234, 16'h0008, 3'd3, 0);
        run_op(16'h7FFF, 16'h0001, 3'd0, 0);
        run_op(16'h8000, 16'h0001, 3'd1, 0);
        run_op(16'd300,  16'd300,  3'd7, 0);
        run_op(16'd3,    16'd5,    3'd7, 1);
        run_op(16'h0001, 16'h0004, 3'd6, 10);
        run_op(16'hABCD, 16'h0000, 3'd6, 0);
        run_op(16'hFFFF, 16'hFFFF, 3'd7, 0);

        for (int k = 0; k < 40; k++) begin
            run_op(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)),
                   $urandom_range(0, 3));
        end

        run_op(16'h7FFF, 16'h0001, 3'd0, 0);
        Ain      = 16'd300;
        Bin      = 16'd300;
        ALUop    = 3'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out", out, 0);
        chk("async_valid", out_valid, 0);
        chk("async_flags", {Z, N, V}, 0);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready, 1);
        bad = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) bad = 1'b1;
        end
        chk("aborted_no_result", bad, 0);
        run_op(16'h0001, 16'h0001, 3'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
